// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and widths for the dinosaur game sequencer
// Contents:
//   state_e  : game state encoding (IDLE / RUN / GAME_OVER)
//   DIGIT_W  : bits per BCD digit
//   DIGITS   : number of BCD score digits
//   SCORE_W  : total score width
//   SPEED_W  : speed level width
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;
  localparam int SCORE_W = DIGIT_W * DIGITS;
  localparam int SPEED_W = 3;

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - 4-digit BCD incrementer, saturating at 9999
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : add one when not saturated
//   value_o : BCD value, digit 3 most significant
//   sat_o   : 1 when value_o is 9999
module bcd_counter4
  import game_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [SCORE_W-1:0] value_o,
  output logic               sat_o
);

  logic [SCORE_W-1:0] value_q, value_d;
  logic               carry;

  assign sat_o   = (value_q == {DIGITS{DIGIT_W'(9)}});
  assign value_o = value_q;

  // Ripple the increment from the least significant digit; a digit at 9
  // wraps to 0 and passes the carry on.
  always_comb begin
    value_d = value_q;
    carry   = inc_i & ~sat_o;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
          value_d[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          value_d[i*DIGIT_W +: DIGIT_W] = value_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
    if (clr_i) begin
      value_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - dinosaur game sequencer: frame tick, FSM, collision, score, speed
// Optional feature macro: HISCORE_EN (adds hiscore output and register)
// Ports:
//   CLK, RESET   : clock, synchronous active-high reset
//   fresh        : VGA frame signal, falling edge = frame boundary
//   button_jump  : raw asynchronous jump/start button
//   dino_px      : dinosaur sprite pixel
//   obst_px      : obstacle sprite pixel
//   game_status  : 1 while running
//   game_over    : 1 while in GAME_OVER
//   jump_req     : jump request, held until the second frame tick after setting
//   frame_tick   : one-CLK pulse per frame
//   score        : 4-digit BCD score
//   speed_level  : obstacle speed level 0..SPEED_MAX
//   hiscore      : best BCD score since RESET (HISCORE_EN only)
module game_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_DIV  = 6,
  parameter int SPEED_STEP = 100,
  parameter int SPEED_MAX  = 7,
  parameter int HOLDOFF    = 60
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               fresh,
  input  logic               button_jump,
  input  logic               dino_px,
  input  logic               obst_px,
  output logic               game_status,
  output logic               game_over,
  output logic               jump_req,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] score,
`ifdef HISCORE_EN
  output logic [SCORE_W-1:0] hiscore,
`endif
  output logic [SPEED_W-1:0] speed_level
);

  localparam int FRAME_W = $clog2(SCORE_DIV + 1);
  localparam int STEP_W  = $clog2(SPEED_STEP + 1);
  localparam int HOLD_W  = $clog2(HOLDOFF + 1);

  state_e              state_q, state_d;
  logic                fresh_q, frame_tick_q;
  logic                btn_meta_q, btn_sync_q, btn_prev_q;
  logic                btn_rise;
  logic                jump_req_q, jump_seen_q;
  logic                hit_q;
  logic [FRAME_W-1:0]  frame_cnt_q;
  logic [STEP_W-1:0]   step_cnt_q;
  logic [SPEED_W-1:0]  speed_q;
  logic [HOLD_W-1:0]   holdoff_q;
  logic                start_run, enter_over, score_step, score_sat;

  assign btn_rise    = btn_sync_q & ~btn_prev_q;
  assign game_status = (state_q == RUN);
  assign game_over   = (state_q == GAME_OVER);
  assign jump_req    = jump_req_q;
  assign frame_tick  = frame_tick_q;
  assign speed_level = speed_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    enter_over = 1'b0;
    score_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_rise) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        // A collision latched during the frame beats that frame's score step.
        if (frame_tick_q) begin
          if (hit_q) begin
            state_d    = GAME_OVER;
            enter_over = 1'b1;
          end else if (frame_cnt_q == FRAME_W'(SCORE_DIV - 1)) begin
            score_step = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (btn_rise && holdoff_q == HOLD_W'(HOLDOFF)) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fresh_q      <= 1'b0;
      frame_tick_q <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_prev_q   <= 1'b0;
      jump_req_q   <= 1'b0;
      jump_seen_q  <= 1'b0;
      hit_q        <= 1'b0;
      frame_cnt_q  <= '0;
      step_cnt_q   <= '0;
      speed_q      <= '0;
      holdoff_q    <= '0;
    end else begin
      fresh_q      <= fresh;
      frame_tick_q <= fresh_q & ~fresh;
      btn_meta_q   <= button_jump;
      btn_sync_q   <= btn_meta_q;
      btn_prev_q   <= btn_sync_q;

      if (start_run) begin
        jump_req_q  <= 1'b0;
        jump_seen_q <= 1'b0;
        hit_q       <= 1'b0;
        frame_cnt_q <= '0;
        step_cnt_q  <= '0;
        speed_q     <= '0;
      end else if (state_q == RUN) begin
        if (dino_px && obst_px) begin
          hit_q <= 1'b1;
        end
        if (frame_tick_q && !hit_q) begin
          frame_cnt_q <= score_step ? '0 : frame_cnt_q + FRAME_W'(1);
        end
        // Step counter tracks score modulo SPEED_STEP; a saturated score no
        // longer advances it.
        if (score_step && !score_sat) begin
          if (step_cnt_q == STEP_W'(SPEED_STEP - 1)) begin
            step_cnt_q <= '0;
            if (speed_q != SPEED_W'(SPEED_MAX)) begin
              speed_q <= speed_q + SPEED_W'(1);
            end
          end else begin
            step_cnt_q <= step_cnt_q + STEP_W'(1);
          end
        end
        // jump_seen_q marks the first frame tick after the request was raised;
        // a tick in the same CLK as the press does not count.
        if (enter_over) begin
          jump_req_q <= 1'b0;
        end else if (!jump_req_q) begin
          if (btn_rise) begin
            jump_req_q  <= 1'b1;
            jump_seen_q <= 1'b0;
          end
        end else if (frame_tick_q) begin
          if (jump_seen_q) begin
            jump_req_q <= 1'b0;
          end else begin
            jump_seen_q <= 1'b1;
          end
        end
      end

      if (enter_over) begin
        holdoff_q <= '0;
      end else if (state_q == GAME_OVER && frame_tick_q && holdoff_q != HOLD_W'(HOLDOFF)) begin
        holdoff_q <= holdoff_q + HOLD_W'(1);
      end
    end
  end

  bcd_counter4 u_score (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .clr_i   (start_run),
    .inc_i   (score_step),
    .value_o (score),
    .sat_o   (score_sat)
  );

`ifdef HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  assign hiscore = hiscore_q;

  // For valid BCD, an MSD-first digit compare equals a plain unsigned compare.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hiscore_q <= '0;
    end else if (enter_over && score > hiscore_q) begin
      hiscore_q <= score;
    end
  end
`endif

endmodule
